// File: rtl/tx_sequencer_pkg.sv
// Shared types, constants and preamble helpers for the backscatter reply sequencer.
package tx_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_CRC,
    ST_EOS,
    ST_STOP,
    ST_DONE
  } tx_state_e;

  localparam logic [15:0] CRC_POLY           = 16'h1021;
  localparam logic [15:0] CRC_PRESET         = 16'hFFFF;
  localparam logic [4:0]  FM0_PILOT_LEN      = 5'd12;
  localparam logic [4:0]  MILLER_PILOT_LONG  = 5'd16;
  localparam logic [4:0]  MILLER_PILOT_SHORT = 5'd4;
  localparam logic [4:0]  PRE_BODY_LEN       = 5'd6;

  // Preamble bodies, leftmost bit is sent first.
  localparam logic [5:0]  FM0_PRE            = 6'b101001;
  localparam logic [5:0]  MILLER_PRE         = 6'b010111;

  // Number of leading '0' pilot bits for the given modulation.
  function automatic logic [4:0] pilot_len(input logic [1:0] m, input logic trext);
    if (m == 2'd0) return trext ? FM0_PILOT_LEN : 5'd0;
    return trext ? MILLER_PILOT_LONG : MILLER_PILOT_SHORT;
  endfunction

  // Preamble bit at position idx (pilot zeros first, then the body).
  function automatic logic pre_bit(input logic [1:0] m, input logic trext,
                                   input logic [4:0] idx);
    logic [4:0] pilot;
    logic [2:0] k;
    logic [5:0] pat;
    pilot = pilot_len(m, trext);
    k     = 3'(idx - pilot);
    pat   = (m == 2'd0) ? FM0_PRE : MILLER_PRE;
    if (idx < pilot) return 1'b0;
    return pat[3'd5 - k];
  endfunction

endpackage

// File: rtl/tx_sequencer_crc16.sv
// Serial CRC-16/CCITT register, MSB first. Also usable as the rx command checker.
module crc16_serial
  import tx_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        preset_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic        fb;

  assign fb = crc_q[15] ^ bit_i;

  // Preset on request, otherwise fold one bit per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset || preset_i) crc_q <= CRC_PRESET;
    else if (en_i)         crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/tx_sequencer.sv
// Backscatter reply sequencer: preamble, payload, CRC-16, dummy bit, graceful stop.
//
// state | meaning
// IDLE  | modulator held in reset, waiting for start
// PRE   | pilot zeros + FM0/Miller preamble body
// DATA  | payload bits from command logic, CRC accumulates
// CRC   | inverted CRC-16, MSB first
// EOS   | dummy '1'
// STOP  | stop requested, waiting for modulator done or timeout
// DONE  | one-cycle done pulse, back to IDLE
module tx_sequencer
  import tx_sequencer_pkg::*;
#(
  parameter int LEN_W        = 8,
  parameter int STOP_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       m,
  input  logic             trext,
  input  logic             crc_en,
  input  logic [LEN_W-1:0] data_len,
  input  logic             data_bit,
  input  logic             data_valid,
  output logic             data_ack,
  input  logic             tx_bitinclk,
  input  logic             tx_done,
  output logic             tx_reset,
  output logic             tx_bitin,
  output logic             tx_violation,
  output logic             tx_stop,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Loaded on STOP entry and counted down; zero marks STOP_TIMEOUT cycles spent in STOP.
  localparam logic [9:0] TMR_LOAD = 10'(STOP_TIMEOUT - 1);

  tx_state_e        state_q;
  logic             bclk_q;
  logic [1:0]       m_q;
  logic             trext_q;
  logic             crc_en_q;
  logic [LEN_W-1:0] len_q;
  logic [4:0]       idx_q;
  logic [LEN_W-1:0] dcnt_q;
  logic [9:0]       tmr_q;
  logic             error_q;
  logic             data_ack_q;

  logic             adv;
  logic [4:0]       pre_last;
  logic             crc_preset;
  logic             crc_step;
  logic [15:0]      crc_w;

  assign adv      = tx_bitinclk & ~bclk_q;
  assign pre_last = pilot_len(m_q, trext_q) + PRE_BODY_LEN - 5'd1;

  assign crc_preset = (state_q == ST_IDLE) && start;
  assign crc_step   = (state_q == ST_DATA) && adv && data_valid;

  // The CRC register holds its final value during the CRC field; bits are picked by index.
  crc16_serial u_crc (
    .clk      (clk),
    .reset    (reset),
    .preset_i (crc_preset),
    .en_i     (crc_step),
    .bit_i    (data_bit),
    .crc_o    (crc_w)
  );

  // Sequencer FSM: field progression on bit-clock rising edges, stop timeout, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bclk_q     <= 1'b0;
      m_q        <= 2'd0;
      trext_q    <= 1'b0;
      crc_en_q   <= 1'b0;
      len_q      <= '0;
      idx_q      <= 5'd0;
      dcnt_q     <= '0;
      tmr_q      <= 10'd0;
      error_q    <= 1'b0;
      data_ack_q <= 1'b0;
    end else begin
      bclk_q     <= tx_bitinclk;
      data_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            m_q      <= m;
            trext_q  <= trext;
            crc_en_q <= crc_en;
            len_q    <= data_len;
            error_q  <= 1'b0;
            idx_q    <= 5'd0;
            dcnt_q   <= '0;
            state_q  <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (adv) begin
            if (idx_q == pre_last) begin
              idx_q <= 5'd0;
              if (len_q != '0)   state_q <= ST_DATA;
              else if (crc_en_q) state_q <= ST_CRC;
              else               state_q <= ST_EOS;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (adv) begin
            if (data_valid) begin
              data_ack_q <= 1'b1;
              if (dcnt_q == len_q - 1'b1) state_q <= crc_en_q ? ST_CRC : ST_EOS;
              else                        dcnt_q  <= dcnt_q + 1'b1;
            end else begin
              error_q <= 1'b1;
              tmr_q   <= TMR_LOAD;
              state_q <= ST_STOP;
            end
          end
        end
        ST_CRC: begin
          if (adv) begin
            if (idx_q == 5'd15) begin
              idx_q   <= 5'd0;
              state_q <= ST_EOS;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        ST_EOS: begin
          if (adv) begin
            tmr_q   <= TMR_LOAD;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tx_done) begin
            state_q <= ST_DONE;
          end else if (tmr_q == 10'd0) begin
            error_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmr_q <= tmr_q - 10'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bit presented to the modulator for the current field position.
  always_comb begin
    tx_bitin = 1'b0;
    case (state_q)
      ST_PRE:  tx_bitin = pre_bit(m_q, trext_q, idx_q);
      ST_DATA: tx_bitin = data_bit;
      ST_CRC:  tx_bitin = ~crc_w[~idx_q[3:0]];
      ST_EOS:  tx_bitin = 1'b1;
      default: tx_bitin = 1'b0;
    endcase
  end

  assign tx_violation = (state_q == ST_PRE) && (m_q == 2'd0) &&
                        (idx_q == pilot_len(m_q, trext_q) + 5'd4);
  assign tx_reset     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign tx_stop      = (state_q == ST_STOP);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;
  assign data_ack     = data_ack_q;

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed bench for tx_sequencer: bit streams per reply, handshakes, timeout, reset.
module tb_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, trext, crc_en;
  logic [1:0] m;
  logic [7:0] data_len;
  logic       data_bit, data_valid, data_ack;
  logic       tx_bitinclk, tx_done, tx_reset, tx_bitin, tx_violation, tx_stop;
  logic       busy, done, error;

  int total = 0;
  int bad   = 0;
  int ack_cnt  = 0;
  int done_cnt = 0;
  int stop_cyc = 0;

  always #5 clk = ~clk;

  tx_sequencer #(.LEN_W(8), .STOP_TIMEOUT(1023)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .m            (m),
    .trext        (trext),
    .crc_en       (crc_en),
    .data_len     (data_len),
    .data_bit     (data_bit),
    .data_valid   (data_valid),
    .data_ack     (data_ack),
    .tx_bitinclk  (tx_bitinclk),
    .tx_done      (tx_done),
    .tx_reset     (tx_reset),
    .tx_bitin     (tx_bitin),
    .tx_violation (tx_violation),
    .tx_stop      (tx_stop),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every wait goes through here so pulse counters see each negedge.
  task automatic step();
    @(negedge clk);
    if (data_ack === 1'b1) ack_cnt++;
    if (done === 1'b1)     done_cnt++;
    if (tx_stop === 1'b1)  stop_cyc++;
  endtask

  task automatic start_reply(input logic [1:0] mm, input logic tt, input logic cc,
                             input logic [7:0] ll, input logic db, input logic dv);
    m = mm; trext = tt; crc_en = cc; data_len = ll; data_bit = db; data_valid = dv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Emits bit-clock pulses until the sequencer requests stop, recording each bit at its sample.
  task automatic run_bits(input bit disturb, output int n, output logic [63:0] bits,
                          output logic [63:0] viol, output bit busy_ok);
    n = 0; bits = '0; viol = '0; busy_ok = 1'b1;
    if (disturb) tx_done = 1'b1;
    while (tx_stop !== 1'b1 && n < 300) begin
      bits = {bits[62:0], tx_bitin};
      viol = {viol[62:0], tx_violation};
      if (busy !== 1'b1 || tx_reset !== 1'b0) busy_ok = 1'b0;
      tx_bitinclk = 1'b1;
      step();
      tx_bitinclk = 1'b0;
      if (disturb && n == 3) begin
        start = 1'b1; m = 2'd0; trext = 1'b1; tx_done = 1'b0;
      end
      step();
      start = 1'b0;
      step();
      n++;
    end
  endtask

  task automatic wait_done(input bit drive, output bit seen);
    int w = 0;
    if (drive) tx_done = 1'b1;
    while (done !== 1'b1 && w < 2000) begin
      step();
      w++;
    end
    tx_done = 1'b0;
    seen = (done === 1'b1);
  endtask

  task automatic reply(input string tag, input logic [1:0] mm, input logic tt, input logic cc,
                       input logic [7:0] ll, input logic db, input int exp_n,
                       input logic [63:0] exp_bits, input logic [63:0] exp_viol,
                       input int exp_ack, input bit disturb);
    int n, a0;
    logic [63:0] bits, viol;
    bit busy_ok, seen;
    a0 = ack_cnt;
    start_reply(mm, tt, cc, ll, db, 1'b1);
    run_bits(disturb, n, bits, viol, busy_ok);
    chk({tag, ".nbits"}, 64'(n), 64'(exp_n));
    chk({tag, ".bits"}, bits, exp_bits);
    chk({tag, ".viol"}, viol, exp_viol);
    chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
    chk({tag, ".acks"}, 64'(ack_cnt - a0), 64'(exp_ack));
    chk({tag, ".stop"}, 64'(tx_stop), 64'd1);
    wait_done(1'b1, seen);
    chk({tag, ".done"}, 64'({seen, tx_reset, error}), 64'b110);
    step();
    chk({tag, ".idle"}, 64'({busy, done, tx_reset, tx_stop}), 64'b0010);
  endtask

  initial begin
    int n, s0, d0;
    logic [63:0] bits, viol;
    bit busy_ok, seen;

    reset = 1'b1; start = 1'b0; m = 2'd0; trext = 1'b0; crc_en = 1'b0; data_len = 8'd0;
    data_bit = 1'b0; data_valid = 1'b1; tx_bitinclk = 1'b0; tx_done = 1'b0;
    repeat (3) step();
    chk("reset_vals", 64'({tx_reset, busy, done, error, tx_bitin, tx_violation, tx_stop, data_ack}),
        64'b1000_0000);
    reset = 1'b0;
    step();

    // FM0, no pilot, no payload, no CRC: preamble then dummy 1.
    reply("fm0", 2'd0, 1'b0, 1'b0, 8'd0, 1'b1, 7, 64'b1010011, 64'b0000100, 0, 1'b0);
    // FM0 with pilot; also early tx_done and a start while busy, both ignored.
    reply("fm0_pilot", 2'd0, 1'b1, 1'b0, 8'd0, 1'b1, 19,
          64'b000000000000_101001_1, 64'b000000000000_000010_0, 0, 1'b1);
    // Miller M2, short pilot, one '0' payload bit, CRC 16'h1020.
    reply("mil_d0", 2'd1, 1'b0, 1'b1, 8'd1, 1'b0, 28,
          64'b0000_010111_0_0001000000100000_1, 64'd0, 1, 1'b1);
    // Miller M4, long pilot, one '1' payload bit, CRC 16'h0001.
    reply("mil_d1", 2'd2, 1'b1, 1'b1, 8'd1, 1'b1, 40,
          64'b0000000000000000_010111_1_0000000000000001_1, 64'd0, 1, 1'b0);
    // No payload with CRC: inverted preset gives 16 zeros.
    reply("crc_only", 2'd0, 1'b0, 1'b1, 8'd0, 1'b1, 23,
          64'b101001_0000000000000000_1, 64'd2 << 17, 0, 1'b0);
    // Maximum payload length, Miller M8: 4+6+255+1 bits, last 64 all ones.
    reply("len255", 2'd3, 1'b0, 1'b0, 8'd255, 1'b1, 266, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
          255, 1'b0);

    // Underrun on first payload bit, then no tx_done: timeout path.
    s0 = stop_cyc;
    d0 = done_cnt;
    start_reply(2'd0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
    run_bits(1'b0, n, bits, viol, busy_ok);
    chk("under.nbits", 64'(n), 64'd7);
    chk("under.bits", bits, 64'b1010010);
    chk("under.err", 64'({error, tx_stop}), 64'b11);
    wait_done(1'b0, seen);
    chk("tmo.done", 64'({seen, tx_reset}), 64'b11);
    chk("tmo.cycles", 64'(stop_cyc - s0), 64'd1023);
    chk("tmo.pulses", 64'(done_cnt - d0), 64'd1);
    step();
    chk("tmo.sticky", 64'({error, busy, done}), 64'b100);
    repeat (4) step();
    chk("tmo.sticky2", 64'(error), 64'd1);

    // Next start clears error; reset mid-reply aborts without a done pulse.
    data_valid = 1'b1;
    d0 = done_cnt;
    start_reply(2'd1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1);
    chk("restart.err", 64'({error, busy, tx_reset}), 64'b010);
    run_bits_partial();
    reset = 1'b1;
    step();
    chk("midreset", 64'({tx_reset, busy, tx_stop, done, error}), 64'b10000);
    reset = 1'b0;
    repeat (5) step();
    chk("midreset.nodone", 64'(done_cnt - d0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // A few bit-clock pulses into the preamble so the reply is in flight.
  task automatic run_bits_partial();
    for (int i = 0; i < 5; i++) begin
      tx_bitinclk = 1'b1;
      step();
      tx_bitinclk = 1'b0;
      step();
      step();
    end
  endtask

endmodule

// File: doc/tx_sequencer.md
Name: tx_sequencer

Overview:
Controls the backscatter transmitter for one reply. It keeps the tx modulator block in reset until a reply is requested. It then feeds the modulator's bit input with four fields in order: the Gen2 preamble (FM0 or Miller, with optional pilot), a serial payload taken from the command logic, an optional on-the-fly CRC-16, and a dummy '1'. Finally it raises the graceful-stop request and waits for the modulator's done flag.

Parameters:
LEN_W, 8, width of payload bit count
STOP_TIMEOUT, 1023, clk cycles allowed in STOP before a forced abort (10-bit counter)

Ports:
clk  in  1  clock; same clock as the modulator's clkin (2x LF)
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begin a reply (ignored unless IDLE)
m  in  2  modulation: 0=FM0, 1/2/3=Miller M2/M4/M8; latched at start
trext  in  1  pilot tone enable; latched at start
crc_en  in  1  append CRC-16; latched at start
data_len  in  LEN_W  payload bit count; latched at start
data_bit  in  1  current payload bit, MSB first
data_valid  in  1  data_bit valid
data_ack  out  1  one-cycle pulse; payload bit consumed
tx_bitinclk  in  1  modulator's bitinclk, sampled as a level
tx_done  in  1  modulator's txdoneout
tx_reset  out  1  modulator reset; high when not transmitting
tx_bitin  out  1  modulator's bitin
tx_violation  out  1  modulator's violationin
tx_stop  out  1  modulator's txstopin
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of reply
error  out  1  sticky; underrun or timeout; cleared by the next accepted start

Behaviour:
- Reset values: tx_reset=1, busy=0, done=0, error=0, and all other outputs 0. State is IDLE.
- Edge detection: bclk_q registers tx_bitinclk. adv = tx_bitinclk & ~bclk_q. All advances happen on the cycle after adv, so tx_bitin is stable two clk cycles before the next modulator sample.
- Field sequencing:
  - The first bit of each reply is driven while in PRE with tx_reset=0. The modulator's setup override clocks in this first bit.
  - Each adv moves to the next bit.
- States:
  - IDLE: tx_reset=1. On start, latch configuration, preset crc=16'hFFFF, clear error, set idx=0, go to PRE.
  - PRE: bit sequence depends on m and trext.
    - FM0: pilot of 12 '0' bits if trext=1, then 1,0,1,0,0,1. tx_violation=1 only on the fifth preamble bit.
    - Miller: pilot of 16 '0' bits if trext=1, else 4; then 0,1,0,1,1,1. tx_violation is always 0.
    - After the last preamble bit: go to DATA if data_len!=0; else to CRC if crc_en; else to EOS.
  - DATA: tx_bitin=data_bit.
    - On adv with data_valid=1: pulse data_ack and update the CRC. fb=crc[15]^data_bit; crc={crc[14:0],1'b0}^(fb?16'h1021:0).
    - After data_len bits, go to CRC if crc_en, else to EOS.
    - On adv with data_valid=0: set error, go to STOP.
  - CRC: tx_bitin=~crc[15]. Shift crc left by one per adv. After 16 bits, go to EOS.
  - EOS: tx_bitin=1 for one bit. On adv, go to STOP.
  - STOP: tx_stop=1 and a 10-bit timer counts.
    - On tx_done=1, go to DONE.
    - If the timer reaches STOP_TIMEOUT, set error and go to DONE.
  - DONE: done=1 for one cycle, tx_reset=1, return to IDLE.
- Boundary conditions:
  - start while busy is ignored.
  - data_len is counted in bits. The counter width is LEN_W with no wrap, so data_len=255 sends 255 bits.
  - If tx_done rises early (before STOP), the block still proceeds only on adv. The flag is ignored outside STOP.
  - reset mid-reply returns to IDLE immediately with tx_reset=1. No done pulse is issued.

Decomposition:
- Shared package: state encoding enum, CRC_POLY=16'h1021, CRC_PRESET=16'hFFFF, FM0_PILOT_LEN=12, MILLER_PILOT_LONG=16, MILLER_PILOT_SHORT=4.
- Sub-module crc16_serial (preset, enable, bit in, 16-bit register out). The same sub-module is reusable by the rx command checker.

Test Plan:
- FM0, trext=0, data_len=0, crc_en=0 -> tx_bitin per adv is 1,0,1,0,0,1,1. tx_violation is high only on bit 5. Then tx_stop=1; tx_done -> done pulse, tx_reset=1.
- FM0, trext=1 -> 12 zeros precede 1,0,1,0,0,1. busy is high throughout.
- Miller m=1, trext=0, data_len=1 with data_bit=0, crc_en=1 -> 0000 010111, then 0, then CRC 16'h1020 MSB first, then 1. One data_ack pulse.
- data_len=1 with data_bit=1, crc_en=1 -> CRC bits 16'h0001.
- data_len=0, crc_en=1 -> CRC field is 16 zeros.
- data_valid=0 on the first DATA adv -> error=1, tx_stop asserted. If tx_done is never asserted: done pulse after 1023 cycles, error stays set until the next start.
